// File: rtl/can_rx_frame_fifo.sv
// CAN receive frame store: NFILT ID/mask acceptance filters in front of a DEPTH-entry
// frame FIFO. The head entry and its accepting filter index are shown on rd_*.

module can_rx_acc_filter (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        cfg_en,
  input  logic        cfg_ext,
  input  logic [28:0] cfg_id,
  input  logic [28:0] cfg_mask,
  input  logic [28:0] fr_id,
  input  logic        fr_ext,
  output logic        en,
  output logic        match
);
  logic        ext;
  logic [28:0] id, mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en   <= 1'b0;
      ext  <= 1'b0;
      id   <= '0;
      mask <= '0;
    end else if (we) begin
      en   <= cfg_en;
      ext  <= cfg_ext;
      id   <= cfg_id;
      mask <= cfg_mask;
    end
  end

  assign match = en & (fr_ext == ext) & (((fr_id ^ id) & mask) == '0);
endmodule

module can_rx_frame_fifo #(
  parameter int DEPTH      = 4,
  parameter int NFILT      = 2,
  parameter int OVW_OLDEST = 0,
  parameter int WMARK      = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fr_valid,
  input  logic [28:0]   fr_id,
  input  logic          fr_ext,
  input  logic          fr_rtr,
  input  logic [3:0]    fr_dlc,
  input  logic [63:0]   fr_data,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_idx,
  input  logic          cfg_en,
  input  logic          cfg_ext,
  input  logic [28:0]   cfg_id,
  input  logic [28:0]   cfg_mask,
  input  logic          rd_pop,
  input  logic          ovf_clr,
  output logic [28:0]   rd_id,
  output logic          rd_ext,
  output logic          rd_rtr,
  output logic [3:0]    rd_dlc,
  output logic [63:0]   rd_data,
  output logic [2:0]    rd_hit,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          irq
);
  typedef struct packed {
    logic [28:0] id;
    logic        ext;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [2:0]  hit;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [NFILT-1:0]  flt_en, flt_match;
  logic [2:0]        sel_hit;
  logic              accepted, push_req, pop_do, wr_ok, overflow, ovw, wr_en;

  for (genvar k = 0; k < NFILT; k++) begin : g_flt
    can_rx_acc_filter u_flt (
      .clk      (clk),
      .reset    (reset),
      .we       (cfg_we && (cfg_idx == 3'(k))),
      .cfg_en   (cfg_en),
      .cfg_ext  (cfg_ext),
      .cfg_id   (cfg_id),
      .cfg_mask (cfg_mask),
      .fr_id    (fr_id),
      .fr_ext   (fr_ext),
      .en       (flt_en[k]),
      .match    (flt_match[k])
    );
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    sel_hit = 3'd0;
    for (int k = NFILT - 1; k >= 0; k--)
      if (flt_match[k]) sel_hit = 3'(k);
  end

  assign accepted = ~(|flt_en) | (|flt_match);
  assign push_req = fr_valid & accepted;
  assign pop_do   = rd_pop & ~empty;
  assign wr_ok    = push_req & (~full | pop_do);
  assign overflow = push_req & full & ~pop_do;
  assign ovw      = overflow & (OVW_OLDEST != 0);
  assign wr_en    = wr_ok | ovw;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{id: fr_id, ext: fr_ext, rtr: fr_rtr, dlc: fr_dlc,
                                data: fr_data, hit: sel_hit};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en)          wr_ptr <= wr_ptr + 1'b1;
      if (pop_do || ovw)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !pop_do)      count <= count + CW'(1);
      else if (pop_do && !wr_ok) count <= count - CW'(1);
      // A fresh overflow beats a simultaneous clear.
      if (overflow)     ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign irq   = (count >= CW'(WMARK)) | ovf;

  assign head    = mem[rd_ptr];
  assign rd_id   = empty ? '0 : head.id;
  assign rd_ext  = empty ? 1'b0 : head.ext;
  assign rd_rtr  = empty ? 1'b0 : head.rtr;
  assign rd_dlc  = empty ? '0 : head.dlc;
  assign rd_data = empty ? '0 : head.data;
  assign rd_hit  = empty ? '0 : head.hit;
endmodule

// File: tb/tb_can_rx_frame_fifo.sv
// Bench for can_rx_frame_fifo: a drop-new and an overwrite-oldest instance share stimulus;
// expected frames are queued at push time and checked by a monitor on every pop.

module tb_can_rx_frame_fifo;
  typedef struct packed {
    logic [28:0] id;
    logic        ext;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [2:0]  hit;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic fr_valid, fr_ext, fr_rtr, cfg_we, cfg_en, cfg_ext, rd_pop, ovf_clr;
  logic [28:0] fr_id, cfg_id, cfg_mask;
  logic [3:0]  fr_dlc;
  logic [63:0] fr_data;
  logic [2:0]  cfg_idx;

  logic [28:0] rd_id0, rd_id1;
  logic        rd_ext0, rd_ext1, rd_rtr0, rd_rtr1;
  logic [3:0]  rd_dlc0, rd_dlc1;
  logic [63:0] rd_data0, rd_data1;
  logic [2:0]  rd_hit0, rd_hit1, count0, count1;
  logic        empty0, empty1, full0, full1, ovf0, ovf1, irq0, irq1;

  exp_t q0[$], q1[$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  can_rx_frame_fifo #(.DEPTH(4), .NFILT(2), .OVW_OLDEST(0), .WMARK(1)) dut0 (
    .clk(clk), .reset(reset), .fr_valid(fr_valid), .fr_id(fr_id), .fr_ext(fr_ext),
    .fr_rtr(fr_rtr), .fr_dlc(fr_dlc), .fr_data(fr_data), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_ext(cfg_ext), .cfg_id(cfg_id), .cfg_mask(cfg_mask),
    .rd_pop(rd_pop), .ovf_clr(ovf_clr), .rd_id(rd_id0), .rd_ext(rd_ext0), .rd_rtr(rd_rtr0),
    .rd_dlc(rd_dlc0), .rd_data(rd_data0), .rd_hit(rd_hit0), .count(count0),
    .empty(empty0), .full(full0), .ovf(ovf0), .irq(irq0));

  can_rx_frame_fifo #(.DEPTH(4), .NFILT(2), .OVW_OLDEST(1), .WMARK(1)) dut1 (
    .clk(clk), .reset(reset), .fr_valid(fr_valid), .fr_id(fr_id), .fr_ext(fr_ext),
    .fr_rtr(fr_rtr), .fr_dlc(fr_dlc), .fr_data(fr_data), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_ext(cfg_ext), .cfg_id(cfg_id), .cfg_mask(cfg_mask),
    .rd_pop(rd_pop), .ovf_clr(ovf_clr), .rd_id(rd_id1), .rd_ext(rd_ext1), .rd_rtr(rd_rtr1),
    .rd_dlc(rd_dlc1), .rd_data(rd_data1), .rd_hit(rd_hit1), .count(count1),
    .empty(empty1), .full(full1), .ovf(ovf1), .irq(irq1));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic en, input logic ext,
                     input logic [28:0] id, input logic [28:0] mask);
    cfg_idx = idx; cfg_en = en; cfg_ext = ext; cfg_id = id; cfg_mask = mask;
    cfg_we = 1'b1;
    tick;
    cfg_we = 1'b0;
  endtask

  // acc/hit are the hand-derived filter outcome for this frame.
  task automatic push(input logic [28:0] id, input logic ext, input logic rtr,
                      input logic [3:0] dlc, input logic [63:0] data, input bit acc,
                      input logic [2:0] hit, input bit pop, input bit clr);
    exp_t e;
    e.id = id; e.ext = ext; e.rtr = rtr; e.dlc = dlc; e.data = data; e.hit = hit;
    fr_id = id; fr_ext = ext; fr_rtr = rtr; fr_dlc = dlc; fr_data = data;
    fr_valid = 1'b1; rd_pop = pop; ovf_clr = clr;
    if (acc) begin
      if (q0.size() < 4 || pop) q0.push_back(e);
      if (q1.size() == 4 && !pop) void'(q1.pop_front());
      q1.push_back(e);
    end
    tick;
    fr_valid = 1'b0; rd_pop = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rd_pop = 1'b1;
    repeat (n) tick;
    rd_pop = 1'b0;
  endtask

  // Monitor: every accepted pop must present the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rd_pop) begin
      if (!empty0) begin
        if (q0.size() == 0) begin
          n_chk++; $display("FAIL pop0_extra: got id %0h expected no entry", rd_id0);
        end else begin
          e = q0.pop_front();
          chk("head0", {rd_id0, rd_ext0, rd_rtr0, rd_dlc0, rd_data0, rd_hit0}, e);
        end
      end
      if (!empty1) begin
        if (q1.size() == 0) begin
          n_chk++; $display("FAIL pop1_extra: got id %0h expected no entry", rd_id1);
        end else begin
          e = q1.pop_front();
          chk("head1", {rd_id1, rd_ext1, rd_rtr1, rd_dlc1, rd_data1, rd_hit1}, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; fr_valid = 0; fr_id = 0; fr_ext = 0; fr_rtr = 0; fr_dlc = 0; fr_data = 0;
    cfg_we = 0; cfg_idx = 0; cfg_en = 0; cfg_ext = 0; cfg_id = 0; cfg_mask = 0;
    rd_pop = 0; ovf_clr = 0;
    #3;
    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_ovf_irq", {ovf0, irq0, ovf1, irq1}, 0);
    chk("rst_head", {rd_id0, rd_ext0, rd_rtr0, rd_dlc0, rd_data0, rd_hit0}, 0);
    repeat (2) tick;
    reset = 1'b0;
    tick;

    // Filters disabled: everything accepted with hit 0, visible next cycle.
    push(29'h123, 0, 0, 4'd2, 64'hBEEF, 1, 0, 0, 0);
    chk("push1_count", count0, 1);
    chk("push1_empty", empty0, 0);
    chk("push1_irq", irq0, 1);
    chk("push1_rd_id", rd_id0, 29'h123);
    chk("push1_rd_hit", rd_hit0, 0);
    pop_n(1);
    chk("pop1_empty", {empty0, irq0, rd_id0}, {1'b1, 1'b0, 29'h0});

    // Acceptance filters.
    cfg(3'd0, 1, 0, 29'h100, 29'h700);
    cfg(3'd1, 1, 0, 29'h123, 29'h7FF);
    push(29'h123, 0, 0, 4'd8, 64'h0102030405060708, 1, 0, 0, 0);
    chk("flt_low_wins", rd_hit0, 0);
    push(29'h223, 0, 0, 4'd1, 64'h55, 0, 0, 0, 0);
    chk("flt_reject_count", count0, 1);
    chk("flt_reject_ovf", ovf0, 0);
    cfg(3'd2, 1, 0, 29'h223, 29'h7FF);
    push(29'h223, 0, 0, 4'd1, 64'h66, 0, 0, 0, 0);
    chk("flt_idx_ignored", count0, 1);
    push(29'h123, 1, 0, 4'd1, 64'h77, 0, 0, 0, 0);
    chk("flt_ext_mismatch", count0, 1);
    cfg(3'd0, 0, 0, 29'h100, 29'h700);
    push(29'h123, 0, 1, 4'd0, 64'h0, 1, 1, 0, 0);
    chk("flt_hit1_count", count0, 2);
    pop_n(2);
    cfg(3'd1, 0, 0, 29'h0, 29'h0);
    chk("flt_done_empty", empty0, 1);

    // Overflow: drop-new vs overwrite-oldest, back-to-back strobes.
    for (int i = 1; i <= 5; i++)
      push(29'(i), 0, (i == 3), 4'(i), 64'hA500 + 64'(i), 1, 0, 0, 0);
    chk("ovf_count", {count0, count1}, {3'd4, 3'd4});
    chk("ovf_full", {full0, full1}, 2'b11);
    chk("ovf_flag", {ovf0, ovf1}, 2'b11);
    chk("ovf_heads", {rd_id0, rd_id1}, {29'd1, 29'd2});
    pop_n(5);
    chk("ovf_drained", {empty0, empty1, irq0}, 3'b111);
    chk("ovf_drained_head", {rd_id0, rd_data0, rd_hit0}, 0);
    ovf_clr = 1'b1; tick; ovf_clr = 1'b0;
    chk("ovf_clr", {ovf0, irq0, ovf1, irq1}, 0);

    // Full with push+pop, then overflow coinciding with ovf_clr.
    for (int i = 0; i < 4; i++)
      push(29'h10 + 29'(i), 0, 0, 4'd4, 64'hC0DE0000 + 64'(i), 1, 0, 0, 0);
    chk("fill_full", {full0, ovf0}, 2'b10);
    push(29'h14, 0, 0, 4'd4, 64'hC0DE0004, 1, 0, 1, 0);
    chk("pushpop_count", {count0, count1}, {3'd4, 3'd4});
    chk("pushpop_ovf", {ovf0, ovf1}, 2'b00);
    chk("pushpop_head", rd_id0, 29'h11);
    push(29'h15, 0, 0, 4'd4, 64'hC0DE0005, 1, 0, 0, 1);
    chk("clr_vs_ovf", {ovf0, ovf1}, 2'b11);
    chk("ovw_heads", {rd_id0, rd_id1, count1}, {29'h11, 29'h12, 3'd4});
    pop_n(1);
    chk("after_pop3", count0, 3);

    // Filter write in the same cycle as a frame: old (all-disabled) filters apply.
    cfg_idx = 3'd0; cfg_en = 1; cfg_ext = 0; cfg_id = 29'h7FF; cfg_mask = 29'h7FF;
    cfg_we = 1'b1;
    push(29'h2AA, 0, 0, 4'd3, 64'h123456, 1, 0, 0, 0);
    cfg_we = 1'b0;
    chk("same_cycle_cfg", count0, 4);
    push(29'h2AB, 0, 0, 4'd3, 64'h1, 0, 0, 0, 0);
    chk("new_filter_rejects", count0, 4);
    pop_n(1);

    // Asynchronous reset mid-stream with 3 entries held.
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count", {count0, count1}, 0);
    chk("mid_rst_flags", {empty0, ovf0, irq0, empty1, ovf1}, 5'b10010);
    chk("mid_rst_head", rd_id0, 0);
    q0.delete(); q1.delete();
    tick;
    reset = 1'b0;
    tick;
    push(29'h2AA, 0, 0, 4'd5, 64'hFACE, 1, 0, 0, 0);
    chk("post_rst_accept", {count0, rd_id0, rd_hit0}, {3'd1, 29'h2AA, 3'd0});
    pop_n(1);
    chk("final_empty", {empty0, empty1}, 2'b11);

    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
